// File: rtl/floo_pkg.sv
// Shared NoC chimney types: destination id type and ordering-guard defaults.
package floo_pkg;

  localparam int unsigned DstIdWidth = 6;
  localparam int unsigned MaxTxnsPerIdDefault = 8;

  typedef logic [DstIdWidth-1:0] id_t;

endpackage

// File: rtl/floo_id_order_entry.sv
// One per-ID tracking slot: outstanding count plus destination of those txns.
module floo_id_order_entry
  import floo_pkg::*;
#(
  parameter int unsigned DstWidth = DstIdWidth,
  parameter int unsigned MaxTxns  = MaxTxnsPerIdDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  input  logic [DstWidth-1:0] next_dst,
  output logic [DstWidth-1:0] dst,
  output logic                busy,
  output logic                full
);

  localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

  logic [CntWidth-1:0] cnt;

  // Simultaneous inc/dec cancels; a dec at zero is an underflow and holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CntWidth'(1);
    end else if (dec && !inc && busy) begin
      cnt <= cnt - CntWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (inc) begin
      dst <= next_dst;
    end
  end

  assign busy = (cnt != '0);
  assign full = (cnt == CntWidth'(MaxTxns));

endmodule

// File: rtl/floo_id_order_tracker.sv
// Per-ID ordering guard: stalls a request whose ID is in flight elsewhere.
// Optional stall statistics via FLOO_ID_ORDER_TRACKER_STATS_EN.
module floo_id_order_tracker
  import floo_pkg::*;
#(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned DstWidth     = DstIdWidth,
  parameter int unsigned MaxTxnsPerId = MaxTxnsPerIdDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdWidth-1:0]  req_id_i,
  input  logic [DstWidth-1:0] req_dst_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic [IdWidth-1:0]  rsp_id_i,
  input  logic                rsp_last_i,
  output logic                err_o,
  output logic [31:0]         stall_cnt_o
);

  localparam int unsigned NumIds = 2 ** IdWidth;

  logic [NumIds-1:0]   busy;
  logic [NumIds-1:0]   full;
  logic [NumIds-1:0]   inc;
  logic [NumIds-1:0]   dec;
  logic [DstWidth-1:0] dst [NumIds];

  logic allow;
  logic issue;
  logic retire;

  for (genvar i = 0; i < NumIds; i++) begin : g_entry
    floo_id_order_entry #(
      .DstWidth (DstWidth),
      .MaxTxns  (MaxTxnsPerId)
    ) u_entry (
      .clk      (clk_i),
      .rst      (rst_i),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .next_dst (req_dst_i),
      .dst      (dst[i]),
      .busy     (busy[i]),
      .full     (full[i])
    );
  end

  // Never depends on req_ready_i, so an asserted valid cannot drop.
  assign allow = !busy[req_id_i] ||
                 (dst[req_id_i] == req_dst_i && !full[req_id_i]);

  assign req_valid_o = req_valid_i && allow;
  assign req_ready_o = req_ready_i && allow;

  assign issue  = req_valid_o && req_ready_i;
  assign retire = rsp_valid_i && rsp_ready_i && rsp_last_i;

  assign inc = NumIds'(issue) << req_id_i;
  assign dec = NumIds'(retire) << rsp_id_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (retire && !busy[rsp_id_i]) begin
      err_o <= 1'b1;
    end
  end

`ifdef FLOO_ID_ORDER_TRACKER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (req_valid_i && !allow && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_id_order_tracker.sv
// Bench for floo_id_order_tracker: directed scenarios plus random traffic
// checked against a per-ID queue-of-destinations reference model.
module tb_floo_id_order_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_id_i;
  logic [5:0]  req_dst_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic        rsp_ready_i;
  logic [3:0]  rsp_id_i;
  logic        rsp_last_i;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  always #5 clk = ~clk;

  floo_id_order_tracker #(
    .IdWidth      (4),
    .DstWidth     (6),
    .MaxTxnsPerId (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_id_i    (req_id_i),
    .req_dst_i   (req_dst_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_i    (rsp_id_i),
    .rsp_last_i  (rsp_last_i),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // Each ID keeps the destinations of its in-flight transactions.
  logic [5:0]  oq [16][$];
  logic        m_err;
  int unsigned m_stall;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_allow(int id, logic [5:0] d);
    return oq[id].size() == 0 ||
           (oq[id][0] == d && oq[id].size() < 8);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) oq[i].delete();
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  task automatic step(bit vi, int id, int d, bit ri,
                      bit rv, bit rr, int rid, bit rl);
    bit a, issue, retire;
    @(negedge clk);
    req_valid_i = vi;
    req_id_i    = id[3:0];
    req_dst_i   = d[5:0];
    req_ready_i = ri;
    rsp_valid_i = rv;
    rsp_ready_i = rr;
    rsp_id_i    = rid[3:0];
    rsp_last_i  = rl;
    #1;
    a = m_allow(id, d[5:0]);
    check("req_valid_o", {31'd0, req_valid_o}, {31'd0, vi && a});
    check("req_ready_o", {31'd0, req_ready_o}, {31'd0, ri && a});
    check("err_o", {31'd0, err_o}, {31'd0, m_err});
    check("stall_cnt_o", stall_cnt_o, m_stall);
    @(posedge clk);
    issue  = vi && a && ri;
    retire = rv && rr && rl;
`ifdef FLOO_ID_ORDER_TRACKER_STATS_EN
    if (vi && !a && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
    if (issue && retire && id == rid) begin
      if (oq[id].size() == 0) m_err = 1'b1;
      else begin
        void'(oq[id].pop_front());
        oq[id].push_back(d[5:0]);
      end
    end else begin
      if (retire) begin
        if (oq[rid].size() == 0) m_err = 1'b1;
        else void'(oq[rid].pop_front());
      end
      if (issue) oq[id].push_back(d[5:0]);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    req_valid_i = 0; req_id_i = 0; req_dst_i = 0; req_ready_i = 0;
    rsp_valid_i = 0; rsp_ready_i = 0; rsp_id_i = 0; rsp_last_i = 0;
    m_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_err", {31'd0, err_o}, 32'd0);
    check("reset_stall", stall_cnt_o, 32'd0);

    // single request and its B
    step(1, 3, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 3, 1);
    idle();

    // ID 2 to another destination stalls until the R last retires
    step(1, 2, 5, 1, 0, 0, 0, 0);
    step(1, 2, 9, 1, 1, 1, 2, 0);
    step(1, 2, 9, 1, 1, 1, 2, 1);
    step(1, 2, 9, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 2, 1);

    // full at 8 outstanding
    for (int i = 0; i < 9; i++) step(1, 1, 4, 1, 0, 0, 0, 0);
    step(1, 1, 4, 1, 1, 1, 1, 1);
    step(1, 1, 4, 1, 0, 0, 0, 0);

    // same-ID issue and retire in one cycle
    step(1, 0, 4, 1, 0, 0, 0, 0);
    step(1, 0, 4, 1, 1, 1, 0, 1);
    step(1, 0, 9, 1, 0, 0, 0, 0);

    // underflow is sticky
    step(0, 0, 0, 0, 1, 1, 7, 1);
    idle();
    idle();

    // asynchronous reset mid-operation with a blocked request held
    @(negedge clk);
    req_valid_i = 1; req_id_i = 4'd1; req_dst_i = 6'd9; req_ready_i = 1;
    rsp_valid_i = 0;
    #1;
    check("pre_rst_block", {31'd0, req_valid_o}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_err", {31'd0, err_o}, 32'd0);
    check("async_rst_valid", {31'd0, req_valid_o}, 32'd1);
    check("async_rst_ready", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 0;
    m_clear();
    @(negedge clk);
    rst = 1'b0;

    // five stalled cycles on ID 2
    step(1, 2, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 2, 9, 1, 0, 0, 0, 0);
    idle();
`ifdef FLOO_ID_ORDER_TRACKER_STATS_EN
    check("stall_five", stall_cnt_o, 32'd5);
`else
    check("stall_tied", stall_cnt_o, 32'd0);
`endif
    step(0, 0, 0, 0, 1, 1, 2, 1);

    // random traffic: few IDs and two destinations to force conflicts
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
             ($urandom_range(0, 1) != 0) ? 4 : 5, $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < (ph == 0 ? 2 : 6),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3),
             $urandom_range(0, 2) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floo_id_order_tracker.md
# floo_id_order_tracker

Initiator-side ordering guard for one AXI request/response pair (AR/R or AW/B) at the manager port of a chimney, before requests enter the NoC. It is the counterpart of the subordinate-side meta buffer. Per AXI ID it tracks the number of outstanding transactions and their destination. It stalls a new request whose ID is outstanding toward a different destination, so same-ID responses cannot return reordered through different NoC paths. Instantiate once for the read path and once for the write path.

## Interface
Parameters:
- `IdWidth`, 4, AXI ID width; tracked IDs = 2**IdWidth.
- `DstWidth`, 6, width of the destination ID (`id_t` of the route config).
- `MaxTxnsPerId`, 8, maximum outstanding transactions per ID; must be ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  request valid from the AXI manager (AR or AW).
- `req_ready_o`  out  1  request ready toward the manager.
- `req_id_i`  in  IdWidth  request AXI ID.
- `req_dst_i`  in  DstWidth  destination decoded by the address map.
- `req_valid_o`  out  1  request valid toward the NoC packer.
- `req_ready_i`  in  1  request ready from the NoC packer.
- `rsp_valid_i`  in  1  response beat valid (R or B) toward the manager; observed only.
- `rsp_ready_i`  in  1  manager ready on the response; observed only.
- `rsp_id_i`  in  IdWidth  response ID.
- `rsp_last_i`  in  1  last beat; tie to 1 for B.
- `err_o`  out  1  sticky protocol error.
- `stall_cnt_o`  out  32  stall statistics; see Configuration.

## Operation
- Per-ID state:
  - `cnt[id]`, width $clog2(MaxTxnsPerId+1).
  - `dst[id]`, DstWidth.
- Admission: `allow = (cnt[req_id_i]==0) || (dst[req_id_i]==req_dst_i && cnt[req_id_i]<MaxTxnsPerId)`.
- Gating:
  - `req_valid_o = req_valid_i && allow`.
  - `req_ready_o = req_ready_i && allow`.
  - ID, destination and payload pass through unchanged; the block does not drive them.
- Issue event: `req_valid_o && req_ready_i`.
  - `cnt[req_id_i]` increments.
  - `dst[req_id_i]` loads `req_dst_i`.
- Retire event: `rsp_valid_i && rsp_ready_i && rsp_last_i`. `cnt[rsp_id_i]` decrements.
- Issue and retire on the same ID in the same cycle:
  - `cnt` is unchanged.
  - `dst` loads `req_dst_i`. This is legal only because `allow` guaranteed the same destination, or `cnt` was 0. With `cnt` 0, the retire is an underflow (see next rule).
- Retire with `cnt[rsp_id_i]==0` (underflow):
  - `cnt` stays 0.
  - `err_o` sets and stays set until reset.
- Issue and retire on different IDs in the same cycle: both update independently.
- `dst` is never cleared. It is don't-care while `cnt==0`.

## Timing
- Request path is purely combinational; zero added latency.
- State updates are visible the cycle after the event.
- `allow` depends only on registered state and the current request fields, never on `req_ready_i`.
  - A retire can only relax `allow`, so an asserted `req_valid_o` never drops while the request is held stable. AXI valid stability holds.
- A retire in cycle N unblocks a stalled request in cycle N+1, not N.
- Full: at `cnt==MaxTxnsPerId` a same-destination request stalls until a retire.
- Reset:
  - All `cnt` go to 0 and `err_o` to 0.
  - `stall_cnt_o` goes to 0.
  - Outputs `req_valid_o`/`req_ready_o` follow the input gating with `allow=1`.
- Reset mid-operation discards all tracking. Responses to pre-reset requests then raise `err_o`; that is intended.

## Configuration
- Macro: `FLOO_ID_ORDER_TRACKER_STATS_EN`.
- Defined:
  - `stall_cnt_o` is a 32-bit counter that increments every cycle with `req_valid_i && !allow`.
  - It saturates at 0xFFFF_FFFF.
- Undefined: `stall_cnt_o` is tied to '0 and no counter flop exists.

## Structure
- Shared package `floo_pkg` holds:
  - the `id_t` destination typedef used for `req_dst_i`;
  - the default `MaxTxnsPerId` constant.
- Natural sub-module `floo_id_order_entry`, instantiated once per ID, holding:
  - one counter and destination register;
  - inc/dec/load inputs;
  - a `busy` (cnt≠0) output and a `full` output.
- The top level holds:
  - ID demux of the issue/retire strobes;
  - destination compare against the selected entry;
  - gating, the error flag and the stats counter.

## Test plan
- Single request ID 3 to dst 5, then B for ID 3 → `req_valid_o` same cycle; `cnt[3]` goes 1 then 0; `err_o`=0.
- ID 2 issued to dst 5, then ID 2 to dst 9 → second request stalls (`req_valid_o`=0, `req_ready_o`=0). It passes in the cycle after the R last beat for ID 2 retires.
- 8 requests ID 1 to dst 4 with no responses (MaxTxnsPerId=8) → all 8 pass; the 9th stalls; one B retire releases it the next cycle.
- Issue ID 0 to dst 4 while `cnt[0]`=1 (dst 4) and its last beat retires in the same cycle → `cnt[0]` stays 1; no stall.
- B for ID 7 with nothing outstanding → `err_o`=1 next cycle and stays 1. Assert `rst_i` mid-burst → `err_o`=0 and all counters 0 asynchronously.
- With STATS_EN, stall ID 2 for 5 cycles → `stall_cnt_o`=5. Without the macro → `stall_cnt_o`=0.
